// File: rtl/dtt_xbar_pkg.sv
// Shared constants for the crossbar scheduler: default geometry, the
// destination-field width derivation and the contention counter width.
package dtt_xbar_pkg;

  localparam int N_IN_DEF       = 4;
  localparam int N_OUT_DEF      = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W          = 16;

  // Width of an index able to address n items; never below one bit.
  function automatic int dest_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtt_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the winner only when a grant is actually issued.
module dtt_rr_arbiter import dtt_xbar_pkg::*; #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = dest_width(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic          found;
  int            idx;

  // Pick the first requester at or after ptr, wrapping around.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    if (advance) begin
      for (int o = 0; o < N; o++) begin
        idx = (int'(ptr) + o) % N;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          next_ptr   = PW'((idx + 1) % N);
          found      = 1'b1;
        end
      end
    end
  end

  // Pointer register; only a real grant moves it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) ptr <= '0;
    else     ptr <= next_ptr;
  end

endmodule

// File: rtl/dtt_xbar_scheduler.sv
// Crossbar scheduler: each output owns a one-beat slot fed by its own
// round-robin arbiter over the inputs that target it.
module dtt_xbar_scheduler import dtt_xbar_pkg::*; #(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_WIDTH = dest_width(N_OUT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [N_IN*DEST_WIDTH-1:0] in_dest,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  input  logic [N_OUT-1:0]           out_enable,
  output logic [N_OUT*DATA_WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]           out_valid,
  input  logic [N_OUT-1:0]           out_ready,
  output logic [CNT_W-1:0]           conflict_cnt
);

  logic [N_OUT-1:0][N_IN-1:0]       req;
  logic [N_OUT-1:0][N_IN-1:0]       grant;
  logic [N_OUT-1:0]                 can_load;
  logic [N_OUT-1:0][DATA_WIDTH-1:0] sel_data;
  logic                             contention;

  // Request matrix; an out-of-range destination matches no output.
  always_comb begin
    req = '0;
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++)
        req[j][i] = in_valid[i] && (int'(in_dest[i*DEST_WIDTH +: DEST_WIDTH]) == j);
  end

  // A slot accepts when enabled and empty or draining this cycle; never in reset.
  always_comb begin
    for (int j = 0; j < N_OUT; j++)
      can_load[j] = !rst && out_enable[j] && (!out_valid[j] || out_ready[j]);
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_arb
    dtt_rr_arbiter #(.N(N_IN)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req[j]),
      .advance (can_load[j]),
      .grant   (grant[j])
    );
  end

  // Accept strobes and the winning payload per output.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int j = 0; j < N_OUT; j++) begin
      in_ready |= grant[j];
      for (int i = 0; i < N_IN; i++)
        if (grant[j][i]) sel_data[j] |= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output slots: load on grant, otherwise clear valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      // NOTE: payload registers are reset too, so out_data reads zero during reset.
      out_data  <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (|grant[j]) begin
          out_valid[j]                          <= 1'b1;
          out_data[j*DATA_WIDTH +: DATA_WIDTH]  <= sel_data[j];
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

  // A cycle is contended when any output sees two or more requesters.
  always_comb begin
    contention = 1'b0;
    for (int j = 0; j < N_OUT; j++)
      if ($countones(req[j]) >= 2) contention = 1'b1;
  end

  // Saturating contention counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 conflict_cnt <= '0;
    else if (contention && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_dtt_xbar_scheduler.sv
// Bench for dtt_xbar_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-free behavioural slot/pointer model.
module tb_dtt_xbar_scheduler;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI*DW-1:0]  in_data;
  logic [NI*SW-1:0]  in_dest;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [NO-1:0]     out_enable;
  logic [NO*DW-1:0]  out_data;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [15:0]       conflict_cnt;

  dtt_xbar_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_dest      (in_dest),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_enable   (out_enable),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit          m_v   [NO];
  logic [31:0] m_d   [NO];
  int          m_ptr [NO];
  int          m_cnt;
  logic [NI-1:0] m_rdy;     // model's accept vector for the current cycle
  logic [NI-1:0] seen_rdy;  // DUT in_ready sampled in the last step

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NO; j++) begin
      m_v[j] = 1'b0; m_d[j] = '0; m_ptr[j] = 0;
    end
    m_cnt = 0;
    m_rdy = '0;
  endtask

  task automatic set_in(input int i, input bit v, input int dest, input logic [31:0] d);
    in_valid[i]          = v;
    in_dest[i*SW +: SW]  = SW'(dest);
    in_data[i*DW +: DW]  = d;
  endtask

  // One clock: inputs already driven (called just after a falling edge).
  task automatic step();
    int gk [NO];
    int nreq;
    bit contended;
    #1;
    // Registered outputs reflect model state from the previous edge.
    for (int j = 0; j < NO; j++) begin
      check($sformatf("out_valid[%0d]", j), 128'(out_valid[j]), 128'(m_v[j]));
      if (m_v[j]) check($sformatf("out_data[%0d]", j), 128'(out_data[j*DW +: DW]), 128'(m_d[j]));
    end
    check("conflict_cnt", 128'(conflict_cnt), 128'(m_cnt));
    // Model arbitration from the rules: first requester at/after ptr.
    m_rdy = '0;
    contended = 1'b0;
    for (int j = 0; j < NO; j++) begin
      gk[j] = -1;
      nreq = 0;
      for (int i = 0; i < NI; i++)
        if (in_valid[i] && int'(in_dest[i*SW +: SW]) == j) nreq++;
      if (nreq >= 2) contended = 1'b1;
      if (out_enable[j] && (!m_v[j] || out_ready[j]))
        for (int o = 0; o < NI; o++) begin
          int k = (m_ptr[j] + o) % NI;
          if (gk[j] < 0 && in_valid[k] && int'(in_dest[k*SW +: SW]) == j) gk[j] = k;
        end
      if (gk[j] >= 0) m_rdy[gk[j]] = 1'b1;
    end
    seen_rdy = in_ready;
    check("in_ready", 128'(in_ready), 128'(m_rdy));
    // Advance the model to the state after the coming rising edge.
    for (int j = 0; j < NO; j++) begin
      if (gk[j] >= 0) begin
        m_v[j]   = 1'b1;
        m_d[j]   = in_data[gk[j]*DW +: DW];
        m_ptr[j] = (gk[j] + 1) % NI;
      end else if (out_ready[j]) begin
        m_v[j] = 1'b0;
      end
    end
    if (contended && m_cnt < 16'hFFFF) m_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_dest = '0; in_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    out_enable = '1;
    out_ready  = '1;
    model_reset();
    @(negedge clk);
    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset out_data", 128'(out_data), 128'(0));
    check("reset conflict_cnt", 128'(conflict_cnt), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Two inputs contend for output 2.
    set_in(0, 1, 2, 32'hAAAABBBB);
    set_in(1, 1, 2, 32'hCCCCDDDD);
    step();
    check("c1 in_ready", 128'(seen_rdy), 128'(4'b0001));
    set_in(0, 0, 0, 32'h0);
    check("c1 out2", 128'(out_data[2*DW +: DW]), 128'(32'hAAAABBBB));
    step();
    check("c2 in_ready", 128'(seen_rdy), 128'(4'b0010));
    set_in(1, 0, 0, 32'h0);
    check("c2 out2", 128'(out_data[2*DW +: DW]), 128'(32'hCCCCDDDD));
    check("c2 conflict", 128'(conflict_cnt), 128'(16'd1));

    // Two inputs to distinct outputs in one cycle.
    set_in(2, 1, 1, 32'hEEEEFFFF);
    set_in(3, 1, 3, 32'h11112222);
    step();
    check("parallel in_ready", 128'(seen_rdy), 128'(4'b1100));
    idle_inputs();
    check("parallel out_valid", 128'(out_valid & 4'b1010), 128'(4'b1010));
    check("out1 data", 128'(out_data[1*DW +: DW]), 128'(32'hEEEEFFFF));
    check("out3 data", 128'(out_data[3*DW +: DW]), 128'(32'h11112222));
    step();

    // Full contention for output 0: grant order 0,1,2,3,0 back to back.
    do_reset();
    for (int i = 0; i < NI; i++) set_in(i, 1, 0, 32'h5000 + i);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rr grant %0d", c), 128'(seen_rdy), 128'(4'b0001 << (c % 4)));
      if (c > 0) check($sformatf("rr no bubble %0d", c), 128'(out_valid[0]), 128'(1));
      for (int i = 0; i < NI; i++)
        if (seen_rdy[i]) set_in(i, 1, 0, 32'h6000 + c * 16 + i);
    end
    idle_inputs();
    step();

    // Backpressure on output 2 with a waiting requester.
    set_in(0, 1, 2, 32'h0BAD0001);
    step();
    set_in(0, 0, 0, 32'h0);
    set_in(1, 1, 2, 32'h0BAD0002);
    out_ready[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall in_ready %0d", c), 128'(seen_rdy), 128'(0));
      check($sformatf("stall out2 %0d", c), 128'(out_data[2*DW +: DW]), 128'(32'h0BAD0001));
    end
    out_ready[2] = 1'b1;
    step();
    check("release in_ready", 128'(seen_rdy), 128'(4'b0010));
    check("release out2", 128'(out_data[2*DW +: DW]), 128'(32'h0BAD0002));
    idle_inputs();

    // Disabled output grants nothing until enabled.
    out_enable[1] = 1'b0;
    set_in(0, 1, 1, 32'h0000E1E1);
    step();
    check("disabled in_ready", 128'(seen_rdy), 128'(0));
    out_enable[1] = 1'b1;
    step();
    check("enabled in_ready", 128'(seen_rdy), 128'(4'b0001));
    idle_inputs();

    // Fill all slots, then reset asynchronously.
    out_ready = '0;
    for (int i = 0; i < NI; i++) set_in(i, 1, i, 32'h7700 + i);
    step();
    check("fill out_valid", 128'(out_valid), 128'(4'b1111));
    #1 rst = 1'b1;
    #1;
    check("async rst out_valid", 128'(out_valid), 128'(0));
    check("async rst in_ready", 128'(in_ready), 128'(0));
    check("async rst out_data", 128'(out_data), 128'(0));
    @(posedge clk);
    #1;
    check("rst hold out_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    out_ready = '1;
    step();  // first grant on the first edge after release
    check("post-rst grant", 128'(seen_rdy), 128'(4'b1111));
    idle_inputs();

    // Random traffic honouring the hold-while-waiting rule.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++)
        if (!(in_valid[i] && !m_rdy[i]))
          set_in(i, ($urandom % 100) < 70, int'($urandom % NO), $urandom);
      for (int j = 0; j < NO; j++) begin
        out_ready[j]  = ($urandom % 100) < 75;
        out_enable[j] = ($urandom % 100) < 85;
      end
      step();
    end

    // Saturate the contention counter.
    out_enable = '1;
    out_ready  = '1;
    for (int i = 0; i < NI; i++) set_in(i, 1, 0, 32'h9000 + i);
    for (int c = 0; c < 65540; c++) step();
    check("conflict saturated", 128'(conflict_cnt), 128'(16'hFFFF));
    step();
    check("conflict holds", 128'(conflict_cnt), 128'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dtt_xbar_scheduler.md
DTT_XBAR_SCHEDULER -- requirements
Module: dtt_xbar_scheduler

Interface
REQ-001 Parameter N_IN, default 4: number of input ports.
REQ-002 Parameter N_OUT, default 4: number of output ports.
REQ-003 Parameter DATA_WIDTH, default 32: payload width.
REQ-004 Parameter DEST_WIDTH, default $clog2(N_OUT): destination field width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_data  input  N_IN*DATA_WIDTH  flat payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_dest  input  N_IN*DEST_WIDTH  flat destination indices; port i occupies bits [i*DEST_WIDTH +: DEST_WIDTH].
REQ-010 in_valid  input  N_IN  per-input request.
REQ-011 in_ready  output  N_IN  per-input grant/accept, combinational.
REQ-012 out_enable  input  N_OUT  per-output enable mask; a disabled output grants nothing.
REQ-013 out_data  output  N_OUT*DATA_WIDTH  registered flat payloads, same packing as in_data.
REQ-014 out_valid  output  N_OUT  registered; output slot holds a beat.
REQ-015 out_ready  input  N_OUT  downstream consumer accepts the beat.
REQ-016 conflict_cnt  output  16  saturating count of contention cycles.

Function
REQ-017 Input i SHALL request output j when in_valid[i]=1 and in_dest[i]=j; a dest value >= N_OUT SHALL never be granted and SHALL hold in_ready[i]=0.
REQ-018 Each output SHALL own one single-beat slot; the slot can load when out_enable[j]=1 and (out_valid[j]=0 or out_ready[j]=1).
REQ-019 When a slot can load, exactly one requester SHALL be granted by round-robin, starting the search at ptr[j] and wrapping from N_IN-1 to 0.
REQ-020 in_ready[i]=1 SHALL occur in the same cycle as the grant; the transfer completes on that edge.
REQ-021 On a grant to input k, ptr[j] SHALL become (k+1) mod N_IN; with no grant, ptr[j] SHALL be unchanged.
REQ-022 The granted payload SHALL appear on out_data[j] with out_valid[j]=1 one cycle after the grant (latency 1).
REQ-023 out_valid[j] SHALL remain 1 and out_data[j] SHALL remain stable until a cycle with out_ready[j]=1.
REQ-024 Simultaneous out_ready[j]=1 and a new grant SHALL replace the beat with no bubble, sustaining full throughput.
REQ-025 With out_ready[j]=1, no grant and out_valid[j]=1, out_valid[j] SHALL clear on the next edge.
REQ-026 Inputs SHALL hold in_data and in_dest stable while in_valid=1 and in_ready=0; the scheduler relies on this.
REQ-027 Different outputs SHALL schedule independently; up to min(N_IN,N_OUT) transfers per cycle.
REQ-028 Deasserting out_enable[j] SHALL block new grants only; a beat already in the slot SHALL still drain normally.
REQ-029 conflict_cnt SHALL increment by 1 in each cycle where at least one output has >=2 requesters, and SHALL saturate at 16'hFFFF.

Reset
REQ-030 While rst=1: out_valid=0, out_data=0, every ptr=0, conflict_cnt=0, in_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard slot contents immediately; no grant SHALL complete during reset.
REQ-032 The first grant after reset release SHALL occur on the first rising edge with rst=0.

Structure
REQ-033 Package dtt_xbar_pkg SHALL hold default N_IN, N_OUT, DATA_WIDTH, the DEST_WIDTH derivation and the conflict counter width constant.
REQ-034 Sub-module dtt_rr_arbiter (N-request, one-hot grant, pointer register, advance input) SHALL be instantiated once per output.

Verification
REQ-035 Reset, then inputs 0 and 1 both dest 2 with data AAAABBBB/CCCCDDDD, out_ready=all 1 -> cycle 1: in_ready=0001, out 2=AAAABBBB; cycle 2: in_ready=0010, out 2=CCCCDDDD; conflict_cnt=1.
REQ-036 Input 2 dest 1 EEEEFFFF and input 3 dest 3 11112222 in the same cycle -> both accepted that cycle; out 1 and out 3 valid next cycle.
REQ-037 All 4 inputs continuously request dest 0 -> grant order 0,1,2,3,0, with one beat per cycle and no bubbles.
REQ-038 out_ready[2]=0 for 3 cycles with a waiting requester -> out_data[2] stable, in_ready stays 0; after release, the next beat loads on the same edge.
REQ-039 out_enable[1]=0 while input 0 requests dest 1 -> no grant; enabling it grants on the next cycle. Reset asserted with slots full -> all out_valid=0 asynchronously.
REQ-040 Force 65536+ contention cycles -> conflict_cnt holds at FFFF.
